// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg: shared state encoding, widths and next-PC select codes. Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

   localparam int          INSTR_W = 32;
   localparam logic [31:0] PC_INC  = 32'd4;

   localparam logic [1:0] ST_RESET_ENC = 2'd0;
   localparam logic [1:0] ST_FETCH_ENC = 2'd1;
   localparam logic [1:0] ST_ISSUE_ENC = 2'd2;
   localparam logic [1:0] ST_HALT_ENC  = 2'd3;

   typedef enum logic [1:0] {
      RESET_ST = ST_RESET_ENC,
      FETCH    = ST_FETCH_ENC,
      ISSUE    = ST_ISSUE_ENC,
      HALT     = ST_HALT_ENC
   } fetch_state_t;

   localparam logic [1:0] SEQ = 2'd0;
   localparam logic [1:0] BR  = 2'd1;
   localparam logic [1:0] JMP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// next_pc_calc: combinational next-PC selection (sequential/branch/jump). Rev 1.0
// ============================================================================
`default_nettype none

module next_pc_calc
   import fetch_pkg::*;
(
   input  logic [31:0] pc_out,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        branch_taken,
   input  logic [15:0] branch_offset,
   output logic [31:0] next_pc
);

   logic [1:0]  sel;
   logic [31:0] seq_pc;
   logic [31:0] br_off;

   always_comb begin
      seq_pc = pc_out + PC_INC;
      br_off = {{14{branch_offset[15]}}, branch_offset, 2'b00};
      // jump has priority over a simultaneous taken branch
      if (jump)              sel = JMP;
      else if (branch_taken) sel = BR;
      else                   sel = SEQ;
      case (sel)
         JMP:     next_pc = {seq_pc[31:28], jump_target, 2'b00};
         BR:      next_pc = seq_pc + br_off;
         default: next_pc = seq_pc;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer: multi-cycle PC owner / imem fetch controller with watchdog. Rev 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ready,
   input  logic [31:0]        imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr_out,
   output logic [31:0]        pc_out,
   input  logic               core_accept,
   input  logic               jump,
   input  logic [25:0]        jump_target,
   input  logic               branch_taken,
   input  logic [15:0]        branch_offset,
   output logic               timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   fetch_state_t       state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic               imem_req_q, imem_req_d;
   logic               instr_valid_q, instr_valid_d;
   logic [INSTR_W-1:0] instr_out_q, instr_out_d;
   logic [31:0]        pc_out_q, pc_out_d;
   logic               timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]   wait_inc;
   logic [31:0]        next_pc;

   next_pc_calc u_next_pc (
      .pc_out        (pc_out_q),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .next_pc       (next_pc)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      imem_req_d    = imem_req_q;
      instr_valid_d = instr_valid_q;
      instr_out_d   = instr_out_q;
      pc_out_d      = pc_out_q;
      timeout_err_d = timeout_err_q;
      wait_cnt_d    = wait_cnt_q;
      wait_inc      = wait_cnt_q + CNT_W'(1);
      case (state_q)
         RESET_ST: begin
            state_d    = FETCH;
            imem_req_d = 1'b1;
            wait_cnt_d = '0;
         end
         FETCH: begin
            if (imem_ready) begin
               instr_out_d   = imem_rdata;
               pc_out_d      = pc_q;
               instr_valid_d = 1'b1;
               imem_req_d    = 1'b0;
               wait_cnt_d    = '0;
               state_d       = ISSUE;
            end else if (wait_inc == CNT_W'(TIMEOUT)) begin
               wait_cnt_d    = wait_inc;
               timeout_err_d = 1'b1;
               imem_req_d    = 1'b0;
               state_d       = HALT;
            end else begin
               wait_cnt_d = wait_inc;
            end
         end
         ISSUE: begin
            // redirect inputs only matter in the handshake cycle
            if (core_accept) begin
               pc_d          = next_pc;
               instr_valid_d = 1'b0;
               wait_cnt_d    = '0;
               imem_req_d    = 1'b1;
               state_d       = FETCH;
            end
         end
         HALT: begin
            imem_req_d    = 1'b0;
            instr_valid_d = 1'b0;
            timeout_err_d = 1'b1;
         end
         default: state_d = RESET_ST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= RESET_ST;
         pc_q          <= RESET_PC;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         instr_out_q   <= '0;
         pc_out_q      <= '0;
         timeout_err_q <= 1'b0;
         wait_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         imem_req_q    <= imem_req_d;
         instr_valid_q <= instr_valid_d;
         instr_out_q   <= instr_out_d;
         pc_out_q      <= pc_out_d;
         timeout_err_q <= timeout_err_d;
         wait_cnt_q    <= wait_cnt_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = pc_q;
   assign instr_valid = instr_valid_q;
   assign instr_out   = instr_out_q;
   assign pc_out      = pc_out_q;
   assign timeout_err = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer. Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        imem_req, imem_ready, instr_valid, core_accept, jump, branch_taken, timeout_err;
   logic [31:0] imem_addr, imem_rdata, instr_out, pc_out;
   logic [25:0] jump_target;
   logic [15:0] branch_offset;

   logic        req_j, ready_j, valid_j, accept_j, jump_j, br_j, err_j;
   logic [31:0] addr_j, rdata_j, instr_j, pc_out_j;
   logic [25:0] jt_j;
   logic [15:0] bo_j;

   fetch_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .instr_out(instr_out), .pc_out(pc_out), .core_accept(core_accept), .jump(jump),
      .jump_target(jump_target), .branch_taken(branch_taken),
      .branch_offset(branch_offset), .timeout_err(timeout_err)
   );

   fetch_sequencer #(.RESET_PC(32'h4000_0010), .TIMEOUT(16)) dut_j (
      .clk(clk), .reset(reset), .imem_req(req_j), .imem_addr(addr_j),
      .imem_ready(ready_j), .imem_rdata(rdata_j), .instr_valid(valid_j),
      .instr_out(instr_j), .pc_out(pc_out_j), .core_accept(accept_j), .jump(jump_j),
      .jump_target(jt_j), .branch_taken(br_j), .branch_offset(bo_j), .timeout_err(err_j)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic [31:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
   endfunction

   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic j,
                                              input logic [25:0] jt, input logic b,
                                              input logic [15:0] bo);
      logic [31:0] seq, off;
      seq = pc + 32'd4;
      off = {{16{bo[15]}}, bo};
      if (j) return (seq & 32'hF000_0000) | {4'h0, jt, 2'b00};
      if (b) return seq + off * 32'd4;
      return seq;
   endfunction

   task automatic wait_req(input int budget);
      int n = 0;
      while (!imem_req && n < budget) begin
         tick;
         n++;
      end
      check_eq("req_seen", {31'd0, imem_req}, 32'd1);
   endtask

   // One full fetch + issue, with optional imem and consumer stalls
   task automatic do_fetch(input int rdy_dly, input int acc_dly, input logic j,
                           input logic [25:0] jt, input logic b, input logic [15:0] bo,
                           output int t_valid);
      logic [31:0] ea;
      ea = exp_q.pop_front();
      wait_req(8);
      check_eq("imem_addr", imem_addr, ea);
      for (int i = 0; i < rdy_dly; i++) begin
         tick;
         check_eq("req_hold", {30'd0, imem_req, instr_valid}, 32'd2);
         check_eq("addr_hold", imem_addr, ea);
      end
      imem_ready = 1'b1;
      imem_rdata = instr_of(ea);
      tick;
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      t_valid = cyc;
      check_eq("valid", {31'd0, instr_valid}, 32'd1);
      check_eq("req_drop", {31'd0, imem_req}, 32'd0);
      check_eq("instr_out", instr_out, instr_of(ea));
      check_eq("pc_out", pc_out, ea);
      for (int i = 0; i < acc_dly; i++) begin
         jump          = 1'b1;
         branch_taken  = 1'b1;
         jump_target   = 26'($urandom);
         branch_offset = 16'($urandom);
         tick;
         check_eq("valid_hold", {30'd0, imem_req, instr_valid}, 32'd1);
         check_eq("instr_hold", instr_out, instr_of(ea));
         check_eq("pc_out_hold", pc_out, ea);
      end
      core_accept   = 1'b1;
      jump          = j;
      jump_target   = jt;
      branch_taken  = b;
      branch_offset = bo;
      exp_q.push_back(model_next(ea, j, jt, b, bo));
      tick;
      core_accept  = 1'b0;
      jump         = 1'b0;
      branch_taken = 1'b0;
      check_eq("valid_clr", {31'd0, instr_valid}, 32'd0);
   endtask

   initial begin
      int t, t_prev;
      reset = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; core_accept = 1'b0;
      jump = 1'b0; jump_target = '0; branch_taken = 1'b0; branch_offset = '0;
      ready_j = 1'b1; rdata_j = 32'h1234_5678; accept_j = 1'b0;
      jump_j = 1'b0; jt_j = '0; br_j = 1'b0; bo_j = '0;
      tick; tick;
      check_eq("rst_req", {31'd0, imem_req}, 32'd0);
      check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
      check_eq("rst_instr", instr_out, 32'd0);
      check_eq("rst_pc_out", pc_out, 32'd0);
      check_eq("rst_err", {31'd0, timeout_err}, 32'd0);
      check_eq("rst_addr", imem_addr, 32'd0);

      reset = 1'b1;
      exp_q.push_back(32'h0);
      tick;
      check_eq("req_after_rst", {31'd0, imem_req}, 32'd1);

      // back-to-back sequential fetches: one instruction per 2 cycles
      t_prev = 0;
      for (int i = 0; i < 4; i++) begin
         do_fetch(0, 0, 1'b0, 26'h0, 1'b0, 16'h0, t);
         if (i > 0) check_eq("rate", 32'(t - t_prev), 32'd2);
         t_prev = t;
      end
      do_fetch(0, 0, 1'b0, 26'h0, 1'b1, 16'h0003, t);
      do_fetch(0, 0, 1'b0, 26'h0, 1'b1, 16'hFFFE, t);
      do_fetch(3, 2, 1'b0, 26'h0, 1'b0, 16'h0, t);
      do_fetch(1, 1, 1'b1, 26'h3FF_FFFF, 1'b1, 16'h8000, t);
      do_fetch(0, 0, 1'b0, 26'h0, 1'b1, 16'h7FFF, t);

      // watchdog: imem never answers
      wait_req(8);
      check_eq("to_addr", imem_addr, exp_q[0]);
      for (int i = 0; i < 15; i++) begin
         tick;
         check_eq("to_wait", {30'd0, timeout_err, imem_req}, 32'd1);
      end
      tick;
      check_eq("to_err", {29'd0, timeout_err, imem_req, instr_valid}, 32'd4);
      imem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         check_eq("halt_hold", {29'd0, timeout_err, imem_req, instr_valid}, 32'd4);
      end
      imem_ready = 1'b0;

      reset = 1'b0;
      tick;
      check_eq("rst_clr", {29'd0, timeout_err, imem_req, instr_valid}, 32'd0);
      reset = 1'b1;
      exp_q.delete();
      exp_q.push_back(32'h0);
      tick;
      check_eq("restart_req", {31'd0, imem_req}, 32'd1);
      do_fetch(0, 0, 1'b0, 26'h0, 1'b0, 16'h0, t);

      // reset lands on the same edge imem_ready answers
      wait_req(8);
      check_eq("mid_addr", imem_addr, exp_q[0]);
      reset      = 1'b0;
      imem_ready = 1'b1;
      imem_rdata = 32'hFACE_F00D;
      tick;
      reset      = 1'b1;
      imem_ready = 1'b0;
      check_eq("mid_valid", {31'd0, instr_valid}, 32'd0);
      check_eq("mid_instr", instr_out, 32'd0);
      check_eq("mid_pc_out", pc_out, 32'd0);
      exp_q.delete();
      exp_q.push_back(32'h0);
      tick;
      check_eq("mid_req", {31'd0, imem_req}, 32'd1);

      // negative branch wraps below zero, then PC wraps past the top
      do_fetch(0, 0, 1'b0, 26'h0, 1'b1, 16'h8000, t);
      do_fetch(0, 0, 1'b1, 26'h3FF_FFFF, 1'b0, 16'h0, t);
      do_fetch(0, 0, 1'b0, 26'h0, 1'b0, 16'h0, t);
      do_fetch(0, 0, 1'b0, 26'h0, 1'b0, 16'h0, t);

      // jump with simultaneous branch on the high-region instance
      check_eq("j_valid", {31'd0, valid_j}, 32'd1);
      check_eq("j_pc_out", pc_out_j, 32'h4000_0010);
      check_eq("j_instr", instr_j, 32'h1234_5678);
      accept_j = 1'b1; jump_j = 1'b1; jt_j = 26'h000020; br_j = 1'b1; bo_j = 16'h0005;
      tick;
      accept_j = 1'b0; jump_j = 1'b0; br_j = 1'b0;
      check_eq("j_req", {31'd0, req_j}, 32'd1);
      check_eq("j_addr", addr_j, 32'h4000_0080);
      tick;
      check_eq("j_pc_out2", pc_out_j, 32'h4000_0080);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
